// File: rtl/bldc_seq_pkg.sv
// rtl/bldc_seq_pkg.sv - shared state encoding, fault codes and Hall validity helper for the start-up sequencer
package bldc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ALIGN    = 3'd1,
        RAMP     = 3'd2,
        RUN      = 3'd3,
        RAMPDOWN = 3'd4,
        FAULT    = 3'd5
    } seq_state_e;

    localparam logic [1:0] FAULT_NONE       = 2'd0;
    localparam logic [1:0] FAULT_HALL       = 2'd1;
    localparam logic [1:0] FAULT_STALL_RAMP = 2'd2;
    localparam logic [1:0] FAULT_STALL_RUN  = 2'd3;

    localparam logic [2:0] HALL_INVALID_LO = 3'b000;
    localparam logic [2:0] HALL_INVALID_HI = 3'b111;

    function automatic logic hall_invalid(input logic [2:0] hall);
        return (hall == HALL_INVALID_LO) || (hall == HALL_INVALID_HI);
    endfunction

endpackage

// File: rtl/bldc_ramp_gen.sv
// rtl/bldc_ramp_gen.sv - tick divider plus saturating up/down duty register; doubles as the reference register
module bldc_ramp_gen #(
    parameter logic [15:0] RAMP_DIV  = 16'd10_000,
    parameter logic [11:0] RAMP_STEP = 12'd4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [11:0] i_load_val,
    input  logic        i_dir_up,
    input  logic [11:0] i_ceiling,
    input  logic        i_en,
    output logic [11:0] o_value,
    output logic        o_at_limit
);

    logic [15:0] div_q, div_d;
    logic [11:0] value_q, value_d;
    logic [12:0] up_sum;
    logic        tick;

    always_comb begin
        div_d   = div_q;
        value_d = value_q;
        tick    = (div_q == RAMP_DIV - 16'd1);
        // 13-bit sum so a step near 4095 saturates instead of wrapping
        up_sum  = {1'b0, value_q} + {1'b0, RAMP_STEP};
        if (i_load) begin
            div_d   = '0;
            value_d = i_load_val;
        end else if (i_en) begin
            if (tick) begin
                div_d = '0;
                if (i_dir_up) begin
                    value_d = (up_sum >= {1'b0, i_ceiling}) ? i_ceiling : up_sum[11:0];
                end else begin
                    value_d = (value_q > RAMP_STEP) ? (value_q - RAMP_STEP) : 12'd0;
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_q   <= '0;
            value_q <= '0;
        end else begin
            div_q   <= div_d;
            value_q <= value_d;
        end
    end

    assign o_value    = value_q;
    assign o_at_limit = i_dir_up ? (value_q == i_ceiling) : (value_q == 12'd0);

endmodule

// File: rtl/bldc_startup_sequencer.sv
// rtl/bldc_startup_sequencer.sv - BLDC align/ramp/hand-off/stop/fault sequencer ahead of the PI controller
// Optional stall detection is built when BLDC_SEQ_STALL_DETECT_EN is defined.
module bldc_startup_sequencer
    import bldc_seq_pkg::*;
#(
    parameter logic [11:0] ALIGN_DUTY   = 12'd400,
    parameter logic [23:0] ALIGN_CYCLES = 24'd5_000_000,
    parameter logic [15:0] RAMP_DIV     = 16'd10_000,
    parameter logic [11:0] RAMP_STEP    = 12'd4,
    parameter logic [12:0] HANDOFF_RPM  = 13'd300
`ifdef BLDC_SEQ_STALL_DETECT_EN
    ,
    parameter logic [27:0] STALL_CYCLES = 28'd50_000_000
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_fault_clr,
    input  logic        i_rot_ccw_req,
    input  logic [11:0] i_target_ref,
    input  logic [2:0]  i_hall_state,
    input  logic [12:0] i_rpm,
    input  logic        i_rpm_valid,
    output logic        o_enable_control,
    output logic        o_bypass,
    output logic        o_rot_ccw,
    output logic [11:0] o_reference,
    output logic [2:0]  o_state,
    output logic        o_fault,
    output logic [1:0]  o_fault_code
);

    logic [2:0]  hall_s1_q, hall_s2_q;
    seq_state_e  state_q, state_d;
    logic [23:0] align_q, align_d;
    logic        ccw_q, ccw_d;
    logic        enable_q, enable_d;
    logic        bypass_q, bypass_d;
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;
    logic        hall_bad, handoff, stall_ramp, stall_run;
    logic        ramp_load, ramp_en, ramp_up, ramp_at_limit;
    logic [11:0] ramp_load_val, ramp_value;

    always_comb begin
        state_d  = state_q;
        ccw_d    = ccw_q;
        code_d   = code_q;
        hall_bad = hall_invalid(hall_s2_q);
        handoff  = i_rpm_valid && (i_rpm >= HANDOFF_RPM);
        // within each state: fault first, then stop, then timer/hand-off
        case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = ALIGN;
                    ccw_d   = i_rot_ccw_req;
                end
            end
            ALIGN: begin
                if (i_stop)                                  state_d = RAMPDOWN;
                else if (align_q == ALIGN_CYCLES - 24'd1)    state_d = RAMP;
            end
            RAMP: begin
                if (hall_bad) begin
                    state_d = FAULT;
                    code_d  = FAULT_HALL;
                end else if (stall_ramp) begin
                    state_d = FAULT;
                    code_d  = FAULT_STALL_RAMP;
                end else if (i_stop)  state_d = RAMPDOWN;
                else if (handoff)     state_d = RUN;
            end
            RUN: begin
                if (hall_bad) begin
                    state_d = FAULT;
                    code_d  = FAULT_HALL;
                end else if (stall_run) begin
                    state_d = FAULT;
                    code_d  = FAULT_STALL_RUN;
                end else if (i_stop)  state_d = RAMPDOWN;
            end
            RAMPDOWN: begin
                if (ramp_at_limit) state_d = IDLE;
            end
            FAULT: begin
                if (i_fault_clr && !i_start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != FAULT) code_d = FAULT_NONE;
        align_d  = (state_d == ALIGN && state_q == ALIGN) ? (align_q + 24'd1) : 24'd0;
        enable_d = (state_d == RUN);
        bypass_d = (state_d != RUN);
        fault_d  = (state_d == FAULT);
    end

    // Ramp register holds the reference in every state; outside the ramping states it is reloaded each cycle
    always_comb begin
        ramp_load = (state_d != state_q) || !(state_d == RAMP || state_d == RAMPDOWN);
        ramp_en   = (state_q == RAMP) || (state_q == RAMPDOWN);
        ramp_up   = (state_q == RAMP);
        case (state_d)
            ALIGN, RAMP: ramp_load_val = ALIGN_DUTY;
            RUN:         ramp_load_val = i_target_ref;
            RAMPDOWN:    ramp_load_val = ramp_value;
            default:     ramp_load_val = 12'd0;
        endcase
    end

    bldc_ramp_gen #(
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (ramp_load),
        .i_load_val (ramp_load_val),
        .i_dir_up   (ramp_up),
        .i_ceiling  (i_target_ref),
        .i_en       (ramp_en),
        .o_value    (ramp_value),
        .o_at_limit (ramp_at_limit)
    );

`ifdef BLDC_SEQ_STALL_DETECT_EN
    logic [2:0]  hall_d1_q;
    logic [27:0] stall_q, stall_d;
    logic        hall_edge, stall_hit;

    always_comb begin
        hall_edge  = (hall_s2_q != hall_d1_q);
        stall_hit  = (stall_q == STALL_CYCLES - 28'd1) && !hall_edge;
        stall_ramp = stall_hit && ramp_at_limit;
        stall_run  = stall_hit;
    end

    always_comb begin
        stall_d = stall_q;
        if (hall_edge || (state_d != state_q))     stall_d = '0;
        else if (stall_q != STALL_CYCLES - 28'd1)  stall_d = stall_q + 28'd1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hall_d1_q <= '0;
            stall_q   <= '0;
        end else begin
            hall_d1_q <= hall_s2_q;
            stall_q   <= stall_d;
        end
    end
`else
    assign stall_ramp = 1'b0;
    assign stall_run  = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hall_s1_q <= '0;
            hall_s2_q <= '0;
            state_q   <= IDLE;
            align_q   <= '0;
            ccw_q     <= 1'b0;
            enable_q  <= 1'b0;
            bypass_q  <= 1'b1;
            fault_q   <= 1'b0;
            code_q    <= FAULT_NONE;
        end else begin
            hall_s1_q <= i_hall_state;
            hall_s2_q <= hall_s1_q;
            state_q   <= state_d;
            align_q   <= align_d;
            ccw_q     <= ccw_d;
            enable_q  <= enable_d;
            bypass_q  <= bypass_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
        end
    end

    assign o_enable_control = enable_q;
    assign o_bypass         = bypass_q;
    assign o_rot_ccw        = ccw_q;
    assign o_reference      = ramp_value;
    assign o_state          = state_q;
    assign o_fault          = fault_q;
    assign o_fault_code     = code_q;

endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// tb/tb_bldc_startup_sequencer.sv - directed self-checking bench for bldc_startup_sequencer
module tb_bldc_startup_sequencer;

    localparam int S_IDLE = 0, S_ALIGN = 1, S_RAMP = 2, S_RUN = 3, S_RDN = 4, S_FAULT = 5;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start, i_stop, i_fault_clr, i_rot_ccw_req;
    logic [11:0] i_target_ref;
    logic [2:0]  i_hall_state;
    logic [12:0] i_rpm;
    logic        i_rpm_valid;
    logic        o_enable_control, o_bypass, o_rot_ccw, o_fault;
    logic [11:0] o_reference;
    logic [2:0]  o_state;
    logic [1:0]  o_fault_code;

    logic [20:0] obs, exp_v;
    int          checks = 0;
    int          failures = 0;
    logic [2:0]  hall_seq [6];
    int          hidx = 0;
    int          spin_cnt = 0;
    logic        spin = 1'b0;

    always #5 i_clk = ~i_clk;

    bldc_startup_sequencer #(
        .ALIGN_DUTY   (12'd400),
        .ALIGN_CYCLES (24'd8),
        .RAMP_DIV     (16'd4),
        .RAMP_STEP    (12'd16),
        .HANDOFF_RPM  (13'd300)
`ifdef BLDC_SEQ_STALL_DETECT_EN
        ,
        .STALL_CYCLES (28'd64)
`endif
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .i_stop           (i_stop),
        .i_fault_clr      (i_fault_clr),
        .i_rot_ccw_req    (i_rot_ccw_req),
        .i_target_ref     (i_target_ref),
        .i_hall_state     (i_hall_state),
        .i_rpm            (i_rpm),
        .i_rpm_valid      (i_rpm_valid),
        .o_enable_control (o_enable_control),
        .o_bypass         (o_bypass),
        .o_rot_ccw        (o_rot_ccw),
        .o_reference      (o_reference),
        .o_state          (o_state),
        .o_fault          (o_fault),
        .o_fault_code     (o_fault_code)
    );

    assign obs = {o_enable_control, o_bypass, o_rot_ccw, o_reference, o_state, o_fault, o_fault_code};

    function automatic logic [20:0] pk(input int en, input int byp, input int ccw, input int r,
                                       input int st, input int f, input int c);
        return {en[0], byp[0], ccw[0], r[11:0], st[2:0], f[0], c[1:0]};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            if (spin) begin
                spin_cnt++;
                if (spin_cnt % 4 == 0) begin
                    hidx = (hidx + 1) % 6;
                    i_hall_state = hall_seq[hidx];
                end
            end
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_fault_clr = 1'b0; i_rot_ccw_req = 1'b0;
        i_target_ref = 12'd1000; i_hall_state = 3'b001; i_rpm = '0; i_rpm_valid = 1'b0;
        step(2);
        exp_v = pk(0, 1, 0, 0, S_IDLE, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_values got=%h exp=%h", obs, exp_v); end
        i_reset = 1'b0;
        step(3);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL idle_after_reset got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_normal_start;
        i_rot_ccw_req = 1'b1; spin = 1'b1; i_start = 1'b1;
        step(1);
        exp_v = pk(0, 1, 1, 400, S_ALIGN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL align_entry got=%h exp=%h", obs, exp_v); end
        i_rot_ccw_req = 1'b0;
        step(7);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL align_last got=%h exp=%h", obs, exp_v); end
        step(1);
        exp_v = pk(0, 1, 1, 400, S_RAMP, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ramp_entry got=%h exp=%h", obs, exp_v); end
        step(3);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ramp_pre_tick got=%h exp=%h", obs, exp_v); end
        step(1);
        exp_v = pk(0, 1, 1, 416, S_RAMP, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ramp_first_tick got=%h exp=%h", obs, exp_v); end
        step(144);
        exp_v = pk(0, 1, 1, 992, S_RAMP, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ramp_992 got=%h exp=%h", obs, exp_v); end
        step(4);
        exp_v = pk(0, 1, 1, 1000, S_RAMP, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ramp_saturate got=%h exp=%h", obs, exp_v); end
        step(4);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ramp_hold got=%h exp=%h", obs, exp_v); end
        i_rpm = 13'd299; i_rpm_valid = 1'b1;
        step(1);
        i_rpm_valid = 1'b0;
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rpm_below_threshold got=%h exp=%h", obs, exp_v); end
        i_rpm = 13'd300; i_rpm_valid = 1'b1;
        step(1);
        i_rpm_valid = 1'b0;
        exp_v = pk(1, 0, 1, 1000, S_RUN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL handoff got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_stop;
        i_start = 1'b0; i_stop = 1'b1;
        step(1);
        exp_v = pk(0, 1, 1, 1000, S_RDN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rampdown_entry got=%h exp=%h", obs, exp_v); end
        step(4);
        exp_v = pk(0, 1, 1, 984, S_RDN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rampdown_first got=%h exp=%h", obs, exp_v); end
        step(244);
        exp_v = pk(0, 1, 1, 8, S_RDN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rampdown_8 got=%h exp=%h", obs, exp_v); end
        step(4);
        exp_v = pk(0, 1, 1, 0, S_RDN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rampdown_sat_zero got=%h exp=%h", obs, exp_v); end
        step(1);
        exp_v = pk(0, 1, 1, 0, S_IDLE, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rampdown_to_idle got=%h exp=%h", obs, exp_v); end
        i_stop = 1'b0; spin = 1'b0;
    endtask

    task automatic test_invalid_hall;
        i_hall_state = 3'b001; i_rot_ccw_req = 1'b0;
        step(3);
        i_start = 1'b1;
        step(1);
        exp_v = pk(0, 1, 0, 400, S_ALIGN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL align_ccw_relatch got=%h exp=%h", obs, exp_v); end
        step(10);
        i_hall_state = 3'b111;
        step(2);
        exp_v = pk(0, 1, 0, 416, S_RAMP, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL hall_sync_delay got=%h exp=%h", obs, exp_v); end
        step(1);
        exp_v = pk(0, 1, 0, 0, S_FAULT, 1, 1);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL hall_fault got=%h exp=%h", obs, exp_v); end
        i_fault_clr = 1'b1;
        step(1);
        i_fault_clr = 1'b0;
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL clr_ignored_with_start got=%h exp=%h", obs, exp_v); end
        i_start = 1'b0; i_fault_clr = 1'b1;
        step(1);
        i_fault_clr = 1'b0;
        exp_v = pk(0, 1, 0, 0, S_IDLE, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL clr_to_idle got=%h exp=%h", obs, exp_v); end
        i_hall_state = 3'b001;
    endtask

    task automatic test_stall;
        step(3);
        i_start = 1'b1;
        step(11);
        i_rpm = 13'd300; i_rpm_valid = 1'b1;
        step(1);
        i_rpm_valid = 1'b0;
        exp_v = pk(1, 0, 0, 1000, S_RUN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL stall_run_entry got=%h exp=%h", obs, exp_v); end
        step(61);
        i_hall_state = 3'b011;
        step(3);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL stall_edge_at_63 got=%h exp=%h", obs, exp_v); end
        step(63);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL stall_before_limit got=%h exp=%h", obs, exp_v); end
        step(1);
`ifdef BLDC_SEQ_STALL_DETECT_EN
        exp_v = pk(0, 1, 0, 0, S_FAULT, 1, 3);
`endif
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL stall_at_limit got=%h exp=%h", obs, exp_v); end
        i_start = 1'b0; i_reset = 1'b1;
        step(1);
        i_reset = 1'b0; i_hall_state = 3'b001;
        step(3);
    endtask

    task automatic test_simultaneous;
        i_start = 1'b1;
        step(10);
        i_hall_state = 3'b111;
        step(2);
        i_stop = 1'b1;
        step(1);
        exp_v = pk(0, 1, 0, 0, S_FAULT, 1, 1);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL fault_beats_stop got=%h exp=%h", obs, exp_v); end
        i_stop = 1'b0; i_start = 1'b0; i_fault_clr = 1'b1;
        step(1);
        i_fault_clr = 1'b0; i_hall_state = 3'b001;
        step(3);
        i_start = 1'b1;
        step(11);
        i_start = 1'b0; i_stop = 1'b1; i_rpm = 13'd500; i_rpm_valid = 1'b1;
        step(1);
        i_rpm_valid = 1'b0;
        exp_v = pk(0, 1, 0, 400, S_RDN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL stop_beats_handoff got=%h exp=%h", obs, exp_v); end
        step(100);
        exp_v = pk(0, 1, 0, 0, S_RDN, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rampdown_400_zero got=%h exp=%h", obs, exp_v); end
        step(1);
        exp_v = pk(0, 1, 0, 0, S_IDLE, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rampdown_400_idle got=%h exp=%h", obs, exp_v); end
        i_stop = 1'b0;
    endtask

    task automatic test_reset_mid_ramp;
        i_rot_ccw_req = 1'b1; i_start = 1'b1;
        step(14);
        exp_v = pk(0, 1, 1, 416, S_RAMP, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL pre_reset_ramp got=%h exp=%h", obs, exp_v); end
        #3 i_reset = 1'b1;
        #1;
        exp_v = pk(0, 1, 0, 0, S_IDLE, 0, 0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, exp_v); end
        i_start = 1'b0;
        #1 i_reset = 1'b0;
        step(1);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_release_idle got=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        hall_seq[0] = 3'b001; hall_seq[1] = 3'b011; hall_seq[2] = 3'b010;
        hall_seq[3] = 3'b110; hall_seq[4] = 3'b100; hall_seq[5] = 3'b101;
        test_reset();
        test_normal_start();
        test_stop();
        test_invalid_hall();
        test_stall();
        test_simultaneous();
        test_reset_mid_ramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
